// File: rtl/trng_batch_scheduler.sv
// TRNG capture sequencer: settles the ring oscillator, then runs clear / collect / transmit
// batches for a programmed count or continuously, with per-phase timeouts and an error state.
module trng_batch_scheduler #(
   parameter int unsigned SETTLE_CYCLES  = 1000,
   parameter int unsigned CLR_CYCLES     = 16,
   parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
   parameter int unsigned CNT_W          = 16
) (
   input  logic             iClk,
   input  logic             iRst_n,
   input  logic             iRun,
   input  logic [CNT_W-1:0] iNumBatches,
   input  logic             iCollectDone,
   input  logic             iTxDone,
   output logic             oEnOsc,
   output logic             oCollectClr,
   output logic             oCollectEn,
   output logic             oTxStart,
   output logic             oBusy,
   output logic             oErr,
   output logic [CNT_W-1:0] oBatchCount,
   output logic [2:0]       oState
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_SETTLE   = 3'd1;
   localparam logic [2:0] S_CLEAR    = 3'd2;
   localparam logic [2:0] S_COLLECT  = 3'd3;
   localparam logic [2:0] S_TRANSMIT = 3'd4;
   localparam logic [2:0] S_DONE     = 3'd5;
   localparam logic [2:0] S_ERROR    = 3'd6;

   localparam logic [31:0] SETTLE_LAST  = (SETTLE_CYCLES == 32'd0) ? 32'd0 : (SETTLE_CYCLES - 32'd1);
   localparam logic [31:0] CLR_LAST     = (CLR_CYCLES == 32'd0) ? 32'd0 : (CLR_CYCLES - 32'd1);
   localparam logic [31:0] TIMEOUT_LAST = (TIMEOUT_CYCLES == 32'd0) ? 32'd0 : (TIMEOUT_CYCLES - 32'd1);
   localparam logic        TIMEOUT_EN   = (TIMEOUT_CYCLES != 32'd0);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
      if (value == {CNT_W{1'b1}}) begin
         sat_inc = value;
      end else begin
         sat_inc = value + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   endfunction

   logic [2:0]       state_r;
   logic [2:0]       next_state_s;
   logic [31:0]      phase_r;
   logic             cd_sync1_r;
   logic             cd_sync2_r;
   logic             cd_prev_r;
   logic             tx_done_d_r;
   logic             cd_rise_s;
   logic             tx_rise_s;
   logic             timeout_s;
   logic             settle_done_s;
   logic             clr_done_s;
   logic [CNT_W-1:0] limit_r;
   logic [CNT_W-1:0] count_r;
   logic [CNT_W-1:0] new_count_s;
   logic             limit_hit_s;

   logic             en_osc_s;
   logic             collect_clr_s;
   logic             collect_en_s;
   logic             tx_start_s;
   logic             busy_s;
   logic             err_s;

   logic             en_osc_r;
   logic             collect_clr_r;
   logic             collect_en_r;
   logic             tx_start_r;
   logic             busy_r;
   logic             err_r;

   // Collector done crosses from the sample-clock domain; tx done is already local.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         cd_sync1_r  <= 1'b0;
         cd_sync2_r  <= 1'b0;
         cd_prev_r   <= 1'b0;
         tx_done_d_r <= 1'b0;
      end else begin
         cd_sync1_r  <= iCollectDone;
         cd_sync2_r  <= cd_sync1_r;
         cd_prev_r   <= cd_sync2_r;
         tx_done_d_r <= iTxDone;
      end
   end

   assign cd_rise_s     = cd_sync2_r & ~cd_prev_r;
   assign tx_rise_s     = iTxDone & ~tx_done_d_r;
   assign settle_done_s = (phase_r >= SETTLE_LAST);
   assign clr_done_s    = (phase_r >= CLR_LAST);
   assign timeout_s     = TIMEOUT_EN && (phase_r == TIMEOUT_LAST);
   assign new_count_s   = sat_inc(count_r);
   assign limit_hit_s   = (limit_r != {CNT_W{1'b0}}) && (new_count_s == limit_r);

   // State register.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic; dropping iRun aborts everything except an in-flight transmit.
   always_comb begin
      next_state_s = S_IDLE;
      case (state_r)
         S_IDLE: begin
            if (iRun) begin
               next_state_s = S_SETTLE;
            end else begin
               next_state_s = S_IDLE;
            end
         end
         S_SETTLE: begin
            if (!iRun) begin
               next_state_s = S_IDLE;
            end else if (settle_done_s) begin
               next_state_s = S_CLEAR;
            end else begin
               next_state_s = S_SETTLE;
            end
         end
         S_CLEAR: begin
            if (!iRun) begin
               next_state_s = S_IDLE;
            end else if (clr_done_s) begin
               next_state_s = S_COLLECT;
            end else begin
               next_state_s = S_CLEAR;
            end
         end
         S_COLLECT: begin
            if (!iRun) begin
               next_state_s = S_IDLE;
            end else if (cd_rise_s) begin
               next_state_s = S_TRANSMIT;
            end else if (timeout_s) begin
               next_state_s = S_ERROR;
            end else begin
               next_state_s = S_COLLECT;
            end
         end
         S_TRANSMIT: begin
            if (tx_rise_s) begin
               if (limit_hit_s) begin
                  next_state_s = S_DONE;
               end else if (!iRun) begin
                  next_state_s = S_DONE;
               end else begin
                  next_state_s = S_CLEAR;
               end
            end else if (timeout_s) begin
               next_state_s = S_ERROR;
            end else begin
               next_state_s = S_TRANSMIT;
            end
         end
         S_DONE, S_ERROR: begin
            if (!iRun) begin
               next_state_s = S_IDLE;
            end else begin
               next_state_s = state_r;
            end
         end
         default: begin
            next_state_s = S_IDLE;
         end
      endcase
   end

   // Phase counter restarts on every state change and saturates instead of wrapping.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         phase_r <= 32'd0;
      end else if (next_state_s != state_r) begin
         phase_r <= 32'd0;
      end else if (phase_r != 32'hFFFF_FFFF) begin
         phase_r <= phase_r + 32'd1;
      end else begin
         phase_r <= phase_r;
      end
   end

   // Batch limit is captured when a run starts; the count is zero whenever the FSM idles.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         limit_r <= {CNT_W{1'b0}};
         count_r <= {CNT_W{1'b0}};
      end else if (next_state_s == S_IDLE) begin
         limit_r <= limit_r;
         count_r <= {CNT_W{1'b0}};
      end else if (state_r == S_IDLE) begin
         limit_r <= iNumBatches;
         count_r <= {CNT_W{1'b0}};
      end else if ((state_r == S_TRANSMIT) && tx_rise_s) begin
         limit_r <= limit_r;
         count_r <= new_count_s;
      end else begin
         limit_r <= limit_r;
         count_r <= count_r;
      end
   end

   // Output decode from the next state so outputs change together with oState.
   always_comb begin
      en_osc_s      = 1'b0;
      collect_clr_s = 1'b0;
      collect_en_s  = 1'b0;
      busy_s        = 1'b0;
      err_s         = 1'b0;
      tx_start_s    = (next_state_s == S_TRANSMIT) && (state_r != S_TRANSMIT);
      case (next_state_s)
         S_SETTLE: begin
            en_osc_s = 1'b1;
            busy_s   = 1'b1;
         end
         S_CLEAR: begin
            en_osc_s      = 1'b1;
            collect_clr_s = 1'b1;
            busy_s        = 1'b1;
         end
         S_COLLECT: begin
            en_osc_s     = 1'b1;
            collect_en_s = 1'b1;
            busy_s       = 1'b1;
         end
         S_TRANSMIT: begin
            en_osc_s = 1'b1;
            busy_s   = 1'b1;
         end
         S_ERROR: begin
            err_s = 1'b1;
         end
         default: begin
            en_osc_s = 1'b0;
         end
      endcase
   end

   // Output registers.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         en_osc_r      <= 1'b0;
         collect_clr_r <= 1'b0;
         collect_en_r  <= 1'b0;
         tx_start_r    <= 1'b0;
         busy_r        <= 1'b0;
         err_r         <= 1'b0;
      end else begin
         en_osc_r      <= en_osc_s;
         collect_clr_r <= collect_clr_s;
         collect_en_r  <= collect_en_s;
         tx_start_r    <= tx_start_s;
         busy_r        <= busy_s;
         err_r         <= err_s;
      end
   end

   assign oEnOsc      = en_osc_r;
   assign oCollectClr = collect_clr_r;
   assign oCollectEn  = collect_en_r;
   assign oTxStart    = tx_start_r;
   assign oBusy       = busy_r;
   assign oErr        = err_r;
   assign oBatchCount = count_r;
   assign oState      = state_r;

endmodule

// File: tb/tb_trng_batch_scheduler.sv
// Self-checking bench for trng_batch_scheduler with behavioural collector and UART models.
module tb_trng_batch_scheduler;

   localparam int SETTLE = 10;
   localparam int CLR    = 4;
   localparam int TMO    = 200;
   localparam int CW     = 16;

   logic          iClk = 1'b0;
   logic          iRst_n = 1'b0;
   logic          iRun = 1'b0;
   logic [CW-1:0] iNumBatches = '0;
   logic          iCollectDone = 1'b0;
   logic          iTxDone = 1'b0;
   logic          oEnOsc, oCollectClr, oCollectEn, oTxStart, oBusy, oErr;
   logic [CW-1:0] oBatchCount;
   logic [2:0]    oState;

   int checks = 0;
   int failures = 0;

   int cd_delay = 100;
   int tx_delay = 50;
   bit cd_enable = 1'b1;

   trng_batch_scheduler #(
      .SETTLE_CYCLES(SETTLE), .CLR_CYCLES(CLR), .TIMEOUT_CYCLES(TMO), .CNT_W(CW)
   ) dut (
      .iClk(iClk), .iRst_n(iRst_n), .iRun(iRun), .iNumBatches(iNumBatches),
      .iCollectDone(iCollectDone), .iTxDone(iTxDone),
      .oEnOsc(oEnOsc), .oCollectClr(oCollectClr), .oCollectEn(oCollectEn),
      .oTxStart(oTxStart), .oBusy(oBusy), .oErr(oErr),
      .oBatchCount(oBatchCount), .oState(oState)
   );

   always #5 iClk = ~iClk;

   // Posedge counter and a negedge monitor logging state entries and pulse activity.
   typedef struct {int st; int at;} ev_t;
   ev_t  trace[$];
   int   clr_widths[$];
   int   cyc = 0;
   int   tx_total = 0;
   int   clr_run = 0;
   logic [2:0] last_st = 3'd0;

   always @(posedge iClk) cyc <= cyc + 1;

   always @(negedge iClk) begin
      if (oState !== last_st) begin
         trace.push_back('{int'(oState), cyc});
         last_st = oState;
      end
      if (oTxStart === 1'b1) tx_total++;
      if (oCollectClr === 1'b1) clr_run++;
      else if (clr_run > 0) begin
         clr_widths.push_back(clr_run);
         clr_run = 0;
      end
   end

   // Collector: raises done cd_delay cycles after enable, drops it on clear or oscillator off.
   initial begin : collector_model
      int en_cnt;
      en_cnt = 0;
      forever begin
         @(negedge iClk);
         if (oCollectEn === 1'b1 && cd_enable) begin
            en_cnt++;
            if (en_cnt == cd_delay) iCollectDone = 1'b1;
         end else begin
            en_cnt = 0;
            if (oCollectClr === 1'b1 || oEnOsc !== 1'b1) iCollectDone = 1'b0;
         end
      end
   end

   // UART: raises tx_done for two cycles, tx_delay cycles after the start pulse.
   initial begin : uart_model
      int tx_t;
      tx_t = -1;
      forever begin
         @(negedge iClk);
         if (iRst_n !== 1'b1) tx_t = -1;
         else if (oTxStart === 1'b1) tx_t = 0;
         else if (tx_t >= 0) tx_t++;
         iTxDone = (tx_t >= tx_delay) && (tx_t < tx_delay + 2);
         if (tx_t >= tx_delay + 2) tx_t = -1;
      end
   end

   task automatic tick();
      @(negedge iClk);
      #1;
   endtask

   task automatic wait_state(input logic [2:0] s, input int budget);
      int k;
      k = 0;
      while (oState !== s && k < budget) begin
         tick();
         k++;
      end
   endtask

   task automatic go_idle();
      iRun = 1'b0;
      wait_state(3'd0, 20);
      tick();
   endtask

   // Expected state trace for a run of n completed batches ending in DONE.
   function automatic bit trace_ok(input int base, input int n);
      int exp_q[$];
      exp_q.push_back(1);
      for (int b = 0; b < n; b++) begin
         exp_q.push_back(2);
         exp_q.push_back(3);
         exp_q.push_back(4);
      end
      exp_q.push_back(5);
      if (trace.size() - base != exp_q.size()) return 1'b0;
      for (int i = 0; i < exp_q.size(); i++)
         if (trace[base + i].st != exp_q[i]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic int entry_at(input int idx);
      if (idx < trace.size()) return trace[idx].at;
      return -1000;
   endfunction

   task automatic test_reset();
      repeat (3) tick();
      checks++;
      if ({oEnOsc, oCollectClr, oCollectEn, oTxStart, oBusy, oErr, oBatchCount, oState} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: got state=%0d en=%b err=%b count=%0d, want all zero", oState, oEnOsc, oErr, oBatchCount);
      end
      iRst_n = 1'b1;
      repeat (2) tick();
      checks++;
      if (oState !== 3'd0) begin
         failures++;
         $display("FAIL reset_release_idle: got state=%0d want 0", oState);
      end
      cd_enable = 1'b0;
      iNumBatches = 16'd1;
      iRun = 1'b1;
      wait_state(3'd3, 100);
      repeat (5) tick();
      checks++;
      if (oState !== 3'd3 || oCollectEn !== 1'b1) begin
         failures++;
         $display("FAIL reset_reach_collect: got state=%0d en=%b want 3 / 1", oState, oCollectEn);
      end
      #1 iRst_n = 1'b0;
      #1;
      checks++;
      if ({oEnOsc, oCollectClr, oCollectEn, oTxStart, oBusy, oErr, oBatchCount, oState} !== '0) begin
         failures++;
         $display("FAIL reset_async_mid_collect: got state=%0d en=%b busy=%b, want all zero before clock edge", oState, oEnOsc, oBusy);
      end
      iRun = 1'b0;
      tick();
      iRst_n = 1'b1;
      repeat (3) tick();
      checks++;
      if (oState !== 3'd0 || oEnOsc !== 1'b0) begin
         failures++;
         $display("FAIL reset_after_release: got state=%0d en=%b want 0 / 0", oState, oEnOsc);
      end
      cd_enable = 1'b1;
   endtask

   task automatic run_batches(input string name, input int n, input int cdd, input int txd);
      int base, tx0, cw0, t0;
      bit widths_ok;
      cd_delay = cdd;
      tx_delay = txd;
      base = trace.size();
      tx0 = tx_total;
      cw0 = clr_widths.size();
      t0 = cyc;
      iNumBatches = 16'(n);
      iRun = 1'b1;
      wait_state(3'd5, 5000);
      checks++;
      if (!trace_ok(base, n)) begin
         failures++;
         $display("FAIL %s_trace: got %0d state entries, want %0d in order 1,(2,3,4)x%0d,5", name, trace.size() - base, 3 * n + 2, n);
      end
      checks++;
      if (entry_at(base) != t0 + 1 || entry_at(base + 1) - entry_at(base) != SETTLE ||
          entry_at(base + 2) - entry_at(base + 1) != CLR) begin
         failures++;
         $display("FAIL %s_startup_timing: settle@%0d clear@%0d collect@%0d, want %0d/%0d/%0d", name,
                  entry_at(base), entry_at(base + 1), entry_at(base + 2), t0 + 1, t0 + 1 + SETTLE, t0 + 1 + SETTLE + CLR);
      end
      checks++;
      if (tx_total - tx0 != n) begin
         failures++;
         $display("FAIL %s_tx_pulses: got %0d want %0d", name, tx_total - tx0, n);
      end
      widths_ok = (clr_widths.size() - cw0 == n);
      for (int i = cw0; i < clr_widths.size(); i++) if (clr_widths[i] != CLR) widths_ok = 1'b0;
      checks++;
      if (!widths_ok) begin
         failures++;
         $display("FAIL %s_clr_pulses: got %0d pulses, want %0d pulses of %0d cycles", name, clr_widths.size() - cw0, n, CLR);
      end
      checks++;
      if (oState !== 3'd5 || oBatchCount !== 16'(n) || oBusy !== 1'b0 || oEnOsc !== 1'b0) begin
         failures++;
         $display("FAIL %s_done: got state=%0d count=%0d busy=%b en=%b want 5/%0d/0/0", name, oState, oBatchCount, oBusy, oEnOsc, n);
      end
      repeat (3) tick();
      checks++;
      if (oState !== 3'd5 || oBatchCount !== 16'(n)) begin
         failures++;
         $display("FAIL %s_done_hold: got state=%0d count=%0d want 5/%0d", name, oState, oBatchCount, n);
      end
      iRun = 1'b0;
      repeat (2) tick();
      checks++;
      if (oState !== 3'd0 || oBatchCount !== 16'd0) begin
         failures++;
         $display("FAIL %s_back_to_idle: got state=%0d count=%0d want 0/0", name, oState, oBatchCount);
      end
      tick();
   endtask

   task automatic test_continuous_stop();
      int base, tx0, k;
      cd_delay = $urandom_range(20, 120);
      tx_delay = $urandom_range(10, 100);
      base = trace.size();
      tx0 = tx_total;
      iNumBatches = 16'd0;
      iRun = 1'b1;
      k = 0;
      while (tx_total - tx0 < 5 && k < 5000) begin
         tick();
         k++;
      end
      iRun = 1'b0;
      wait_state(3'd5, 500);
      checks++;
      if (oState !== 3'd5 || oBatchCount !== 16'd5 || tx_total - tx0 != 5) begin
         failures++;
         $display("FAIL continuous_stop: got state=%0d count=%0d tx=%0d want 5/5/5", oState, oBatchCount, tx_total - tx0);
      end
      checks++;
      if (!trace_ok(base, 5)) begin
         failures++;
         $display("FAIL continuous_stop_trace: got %0d entries want 17", trace.size() - base);
      end
      go_idle();
   endtask

   task automatic test_continuous_abort();
      int tx0;
      cd_delay = 100;
      tx0 = tx_total;
      iNumBatches = 16'd0;
      iRun = 1'b1;
      wait_state(3'd3, 100);
      repeat (20) tick();
      iRun = 1'b0;
      tick();
      checks++;
      if (oState !== 3'd0 || tx_total != tx0 || oCollectEn !== 1'b0) begin
         failures++;
         $display("FAIL continuous_abort: got state=%0d tx=%0d en=%b want 0/0/0", oState, tx_total - tx0, oCollectEn);
      end
      repeat (150) tick();
      checks++;
      if (tx_total != tx0) begin
         failures++;
         $display("FAIL continuous_abort_no_tx: got %0d tx pulses want 0", tx_total - tx0);
      end
   endtask

   task automatic test_timeout();
      int base;
      cd_enable = 1'b0;
      base = trace.size();
      iNumBatches = 16'd1;
      iRun = 1'b1;
      wait_state(3'd6, 1000);
      checks++;
      if (oState !== 3'd6 || oErr !== 1'b1 || oEnOsc !== 1'b0 || oBusy !== 1'b0) begin
         failures++;
         $display("FAIL timeout_error: got state=%0d err=%b en=%b busy=%b want 6/1/0/0", oState, oErr, oEnOsc, oBusy);
      end
      checks++;
      if (entry_at(base + 3) - entry_at(base + 2) != TMO) begin
         failures++;
         $display("FAIL timeout_latency: got %0d cycles in collect want %0d", entry_at(base + 3) - entry_at(base + 2), TMO);
      end
      iRun = 1'b0;
      repeat (2) tick();
      checks++;
      if (oErr !== 1'b0 || oState !== 3'd0) begin
         failures++;
         $display("FAIL timeout_clear: got err=%b state=%0d want 0/0", oErr, oState);
      end
      cd_enable = 1'b1;
      tick();
   endtask

   task automatic test_cd_vs_stop();
      int tx0, k;
      cd_delay = $urandom_range(20, 120);
      tx0 = tx_total;
      iNumBatches = 16'd1;
      iRun = 1'b1;
      wait_state(3'd3, 100);
      k = 0;
      while (iCollectDone !== 1'b1 && k < 300) begin
         tick();
         k++;
      end
      @(posedge iClk);
      @(posedge iClk);
      @(negedge iClk);
      iRun = 1'b0;
      tick();
      checks++;
      if (oState !== 3'd0 || tx_total != tx0) begin
         failures++;
         $display("FAIL cd_rise_vs_stop: got state=%0d tx=%0d want 0/0", oState, tx_total - tx0);
      end
      tick();
   endtask

   task automatic test_tx_vs_timeout(input int txd, input logic [2:0] want_state, input logic [CW-1:0] want_count);
      cd_delay = 50;
      tx_delay = txd;
      iNumBatches = 16'd1;
      iRun = 1'b1;
      wait_state(3'd4, 500);
      wait_state(want_state, 400);
      checks++;
      if (oState !== want_state || oBatchCount !== want_count || oErr !== (want_state == 3'd6)) begin
         failures++;
         $display("FAIL tx_vs_timeout_%0d: got state=%0d count=%0d err=%b want %0d/%0d", txd, oState, oBatchCount, oErr, want_state, want_count);
      end
      go_idle();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      run_batches("single", 1, 100, 50);
      run_batches("multi", 3, 100, 50);
      run_batches("random", $urandom_range(2, 4), $urandom_range(20, 120), $urandom_range(10, 100));
      test_continuous_stop();
      test_continuous_abort();
      test_timeout();
      test_cd_vs_stop();
      test_tx_vs_timeout(TMO - 1, 3'd5, 16'd1);
      test_tx_vs_timeout(TMO, 3'd6, 16'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/trng_batch_scheduler.md
# trng_batch_scheduler

Sequencer for the TRNG capture path on the stable 100 MHz clock. It enables the ring oscillator and lets it settle. For each batch it clears and enables the byte collector, waits for collection to finish, starts the UART transmitter and waits for transmit done. It repeats for a programmed number of batches or runs continuously, with per-phase timeouts and an error state.

## Interface
Parameters:
- SETTLE_CYCLES, 1000: iClk cycles oEnOsc is held before the first batch.
- CLR_CYCLES, 16: width of oCollectClr pulse in iClk cycles; covers the slow sample-clock domain.
- TIMEOUT_CYCLES, 50_000_000: max cycles spent in COLLECT or TRANSMIT; 0 disables timeouts.
- CNT_W, 16: width of batch count and batch limit.

Ports:
- iClk  in  1  100 MHz system clock.
- iRst_n  in  1  asynchronous, active-low reset.
- iRun  in  1  level run request.
- iNumBatches  in  CNT_W  batches per run; 0 = continuous; sampled on leaving IDLE.
- iCollectDone  in  1  collector done level; asynchronous (sample-clock domain), synchronized internally.
- iTxDone  in  1  UART tx_done level, iClk domain.
- oEnOsc  out  1  ring-oscillator / entropy enable.
- oCollectClr  out  1  collector clear, active-high.
- oCollectEn  out  1  collector start/enable level.
- oTxStart  out  1  one-cycle UART start pulse.
- oBusy  out  1  high in any state except IDLE, DONE and ERROR.
- oErr  out  1  timeout error flag.
- oBatchCount  out  CNT_W  batches completed in the current run.
- oState  out  3  state encoding, for debug LEDs.

## Operation
- States and encodings: IDLE=0, SETTLE=1, CLEAR=2, COLLECT=3, TRANSMIT=4, DONE=5, ERROR=6. Encoding 7 is unreachable and recovers to IDLE.
- Synchronizing iCollectDone: 2-flop synchronizer, then an edge register; cd_rise = sync & ~prev.
- tx_rise = iTxDone & ~iTxDone_d.
- One 32-bit phase counter, cleared on every state entry.
- IDLE:
  - All outputs low.
  - iRun=1: latch iNumBatches, clear oBatchCount, go to SETTLE.
- SETTLE:
  - oEnOsc=1.
  - Go to CLEAR after SETTLE_CYCLES cycles.
  - iRun=0: go to IDLE.
- CLEAR:
  - oEnOsc=1, oCollectClr=1 for exactly CLR_CYCLES cycles, then COLLECT.
  - iRun=0: go to IDLE.
- COLLECT:
  - oEnOsc=1, oCollectEn=1.
  - cd_rise: go to TRANSMIT.
  - Timeout: go to ERROR.
  - iRun=0: go to IDLE (abort; partial batch discarded).
  - cd_rise and iRun=0 in the same cycle: iRun=0 wins.
- TRANSMIT:
  - oEnOsc=1; oTxStart=1 only in the first cycle of the state.
  - tx_rise: increment oBatchCount, saturating at all-ones. Then:
    - limit≠0 and new count == limit: go to DONE.
    - else iRun=0: go to DONE.
    - else: go to CLEAR.
  - iRun=0 mid-transmit does not abort; the batch completes.
  - Timeout: go to ERROR.
  - tx_rise and timeout in the same cycle: tx_rise wins.
- DONE:
  - All enables low; oBatchCount held.
  - iRun=0: go to IDLE.
- ERROR:
  - oErr=1, all enables low.
  - iRun=0: go to IDLE, clearing oErr.
- Timeout: fires when the phase counter reaches TIMEOUT_CYCLES-1 in COLLECT or TRANSMIT; never fires when TIMEOUT_CYCLES=0.
- All outputs are registered and decoded from the next state. Output changes appear in the same cycle oState changes.

## Timing
- Reset (iRst_n=0, asynchronous): every output 0, state IDLE, synchronizer and edge registers 0. Release is treated as synchronous to iClk.
- Startup: iRun high at edge N, so oState=1 and oEnOsc=1 from edge N+1.
- First batch: CLEAR is entered at N+1+SETTLE_CYCLES; COLLECT at N+1+SETTLE_CYCLES+CLR_CYCLES.
- iCollectDone to oTxStart latency: 3–4 iClk edges (2 sync flops, edge register, state register).
- tx_rise to next action: oBatchCount updates and the next state is entered 1 edge after the iTxDone rise is sampled.
- Between batches: no SETTLE; CLEAR follows TRANSMIT directly.
- Throughput is bounded only by collector and UART; scheduler overhead per batch is CLR_CYCLES+5 cycles max.

## Test plan
- Reset:
  - iRst_n low mid-COLLECT → all outputs 0 immediately, without waiting for a clock edge.
  - After release with iRun=0 → oState=0.
- Single batch (iNumBatches=1, SETTLE_CYCLES=10, CLR_CYCLES=4; collector model asserts done 100 cycles after enable; UART model asserts done 50 cycles after start):
  - States 1→2→3→4→5; exactly one oTxStart pulse; oBatchCount=1.
  - Returns to IDLE on iRun=0.
- Multi-batch (iNumBatches=3) → exactly 3 oTxStart pulses, with an oCollectClr pulse of 4 cycles before each; DONE with oBatchCount=3.
- Continuous (iNumBatches=0):
  - After the 5th TRANSMIT starts, drop iRun → 5th transmit completes, oBatchCount=5, DONE.
  - Drop iRun during COLLECT instead → immediate IDLE, oTxStart never pulses.
- Timeout (TIMEOUT_CYCLES=200, collector never asserts done) → ERROR exactly 200 cycles after COLLECT entry, oErr=1, oEnOsc=0.
  - oErr cleared after iRun=0.
- Simultaneity:
  - cd_rise in the same cycle as iRun=0 → IDLE.
  - tx_rise in the same cycle as timeout → count increments, no ERROR.
